// File: rtl/iuq_cpl_itag_ptr_pkg.sv
// Shared iTag definitions for the completion-table ring: field split, ring
// constants, slot-count helper and the head-to-tail ring distance.
package iuq_cpl_itag_ptr_pkg;

  localparam int ITAG_SIZE     = 7;
  localparam int ITAG_WRAP     = 40;
  localparam int ITAG_DEPTH    = ITAG_WRAP + 1;
  localparam int ITAG_IDX_W    = ITAG_SIZE - 1;
  localparam int ITAG_WRAP_BIT = ITAG_SIZE - 1;
  localparam int ITAG_IDX_MIN  = 0;
  localparam int ITAG_IDX_MAX  = ITAG_WRAP;

  typedef logic [ITAG_SIZE-1:0] itag_cnt_t;

  localparam itag_cnt_t DEPTH_CNT = ITAG_SIZE'(ITAG_DEPTH);
  localparam itag_cnt_t WRAP_CNT  = ITAG_SIZE'(ITAG_WRAP);

  // Wrap (parity) bit sits in the most significant position, index below it.
  typedef struct packed {
    logic                  wrap;
    logic [ITAG_IDX_W-1:0] idx;
  } itag_t;

  // Number of active slots in a 2-bit request/retire vector.
  function automatic logic [1:0] itag_cnt(input logic [1:0] v);
    itag_cnt = {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  // Widen a slot count so it can be compared against occupancy/credits.
  function automatic itag_cnt_t itag_cnt_ext(input logic [1:0] n);
    itag_cnt_ext = {{(ITAG_SIZE-2){1'b0}}, n};
  endfunction

  // Entries from head (inclusive) to tail (exclusive) around the ring.
  // Equal index with differing wrap bits is a full ring.
  function automatic itag_cnt_t itag_dist(input itag_t head, input itag_t tail);
    itag_cnt_t h;
    itag_cnt_t t;
    h = {1'b0, head.idx};
    t = {1'b0, tail.idx};
    if (head.wrap == tail.wrap) begin
      itag_dist = t - h;
    end else begin
      itag_dist = DEPTH_CNT - h + t;
    end
  endfunction

endpackage

// File: rtl/iuq_cpl_itag_ptr_if.sv
// Dispatch/completion-side bundle of the iTag pointer block.
interface iuq_cpl_itag_ptr_if;
  import iuq_cpl_itag_ptr_pkg::*;

  // Allocation handshake: dispatch raises alloc_req (slot 1 only alongside
  // slot 0); alloc_gnt answers combinationally in the same cycle and is
  // all-or-nothing. The request is consumed only in a cycle where alloc_gnt
  // is high; otherwise dispatch may hold or change it freely next cycle.
  // alloc_itag0/1 are valid to use only in a granted cycle.
  logic [1:0] alloc_req;
  logic       alloc_gnt;
  itag_t      alloc_itag0;
  itag_t      alloc_itag1;

  logic [1:0] cmpl_vld;
  logic       flush;
  itag_t      flush_itag;

  itag_t      head_itag;
  itag_t      tail_itag;
  itag_cnt_t  occ_cnt;
  itag_cnt_t  free_cnt;
  logic       empty;
  logic       full;
  logic       cmpl_err;

  modport master (
    output alloc_req, cmpl_vld, flush, flush_itag,
    input  alloc_gnt, alloc_itag0, alloc_itag1,
    input  head_itag, tail_itag, occ_cnt, free_cnt, empty, full, cmpl_err
  );

  modport slave (
    input  alloc_req, cmpl_vld, flush, flush_itag,
    output alloc_gnt, alloc_itag0, alloc_itag1,
    output head_itag, tail_itag, occ_cnt, free_cnt, empty, full, cmpl_err
  );

endinterface

// File: rtl/iuq_cpl_ctrl_inc.sv
// iTag wrapping incrementer: adds 0..2 to an iTag, folding the index past
// ITAG_WRAP back to 0/1 and toggling the wrap bit.
module iuq_cpl_ctrl_inc
  import iuq_cpl_itag_ptr_pkg::*;
(
  input  itag_t      itag_i,
  input  logic [1:0] inc_i,
  output itag_t      itag_o
);

  itag_cnt_t             sum;
  logic [ITAG_IDX_W-1:0] fold;

  always_comb begin
    sum    = {1'b0, itag_i.idx} + {{(ITAG_IDX_W-1){1'b0}}, inc_i};
    // sum never exceeds 2*ITAG_WRAP, so the low bits alone give the folded index.
    fold   = sum[ITAG_IDX_W-1:0] - DEPTH_CNT[ITAG_IDX_W-1:0];
    itag_o = itag_i;
    if (sum > WRAP_CNT) begin
      itag_o.wrap = ~itag_i.wrap;
      itag_o.idx  = fold;
    end else begin
      itag_o.idx  = sum[ITAG_IDX_W-1:0];
    end
  end

endmodule

// File: rtl/iuq_cpl_itag_ptr.sv
// Completion-table iTag ring: tail allocates up to two iTags per cycle to
// dispatch, head retires up to two, flush restores the tail.
module iuq_cpl_itag_ptr
  import iuq_cpl_itag_ptr_pkg::*;
(
  input logic               clk,
  input logic               rst,
  iuq_cpl_itag_ptr_if.slave ptr_if
);

  itag_t      head_q, head_d;
  itag_t      tail_q, tail_d;
  itag_cnt_t  occ_q, occ_d;
  itag_cnt_t  free_q, free_d;
  logic       empty_q, empty_d;
  logic       full_q, full_d;
  logic       err_q, err_d;

  logic [1:0] req_n;
  logic [1:0] ret_n;
  logic       gnt;
  logic       over_ret;
  itag_t      tail_adv;
  itag_t      tail_plus1;
  itag_t      head_adv;

  assign req_n = itag_cnt(ptr_if.alloc_req);
  assign ret_n = itag_cnt(ptr_if.cmpl_vld);

  // Credits come only from the registered count, so a retire in this cycle
  // cannot fund an allocation until the next one.
  assign gnt = (req_n != 2'd0) && (itag_cnt_ext(req_n) <= free_q) && !ptr_if.flush;

  assign over_ret = itag_cnt_ext(ret_n) > occ_q;

  iuq_cpl_ctrl_inc u_tail_inc (
    .itag_i (tail_q),
    .inc_i  (req_n),
    .itag_o (tail_adv)
  );

  iuq_cpl_ctrl_inc u_tail_p1 (
    .itag_i (tail_q),
    .inc_i  (2'd1),
    .itag_o (tail_plus1)
  );

  iuq_cpl_ctrl_inc u_head_inc (
    .itag_i (head_q),
    .inc_i  (ret_n),
    .itag_o (head_adv)
  );

  always_comb begin
    tail_d = tail_q;
    if (ptr_if.flush) begin
      tail_d = ptr_if.flush_itag;
    end else if (gnt) begin
      tail_d = tail_adv;
    end

    head_d = over_ret ? head_q : head_adv;
    err_d  = over_ret;

    // Status is derived from the next pointers so it registers alongside them.
    occ_d   = itag_dist(head_d, tail_d);
    free_d  = DEPTH_CNT - occ_d;
    empty_d = (occ_d == '0);
    full_d  = (occ_d == DEPTH_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      free_q  <= DEPTH_CNT;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign ptr_if.alloc_gnt   = gnt;
  assign ptr_if.alloc_itag0 = tail_q;
  assign ptr_if.alloc_itag1 = tail_plus1;
  assign ptr_if.head_itag   = head_q;
  assign ptr_if.tail_itag   = tail_q;
  assign ptr_if.occ_cnt     = occ_q;
  assign ptr_if.free_cnt    = free_q;
  assign ptr_if.empty       = empty_q;
  assign ptr_if.full        = full_q;
  assign ptr_if.cmpl_err    = err_q;

  // Slot 1 without slot 0 is illegal on both buses; logic above counts it as one.
  a_alloc_req_legal: assert property (@(posedge clk) disable iff (rst)
    ptr_if.alloc_req != 2'b01);

  a_cmpl_vld_legal: assert property (@(posedge clk) disable iff (rst)
    ptr_if.cmpl_vld != 2'b01);

  a_occ_in_range: assert property (@(posedge clk) disable iff (rst)
    occ_q <= DEPTH_CNT);

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, head_q.idx} <= WRAP_CNT) && ({1'b0, tail_q.idx} <= WRAP_CNT));

endmodule

// File: tb/tb_iuq_cpl_itag_ptr.sv
// Directed bench for the completion iTag ring pointers.
module tb_iuq_cpl_itag_ptr;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [30:0] exp_s;

  iuq_cpl_itag_ptr_if bus ();

  iuq_cpl_itag_ptr dut (
    .clk    (clk),
    .rst    (rst),
    .ptr_if (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  // Ring distance in the bench's own terms: wrap bit is bit 6, index bits 5:0.
  function automatic int tb_dist(input logic [6:0] h, input logic [6:0] t);
    int hi;
    int ti;
    hi = int'(h[5:0]);
    ti = int'(t[5:0]);
    if (h[6] == t[6]) return ti - hi;
    return 41 - hi + ti;
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.flush) begin
      assert (tb_dist(bus.head_itag, bus.flush_itag) <= tb_dist(bus.head_itag, bus.tail_itag))
        else $error("flush_itag %h outside head %h .. tail %h", bus.flush_itag, bus.head_itag, bus.tail_itag);
    end
  end

  function automatic logic [30:0] snap();
    return {bus.head_itag, bus.tail_itag, bus.occ_cnt, bus.free_cnt, bus.empty, bus.full, bus.cmpl_err};
  endfunction

  // Expected state word: head, tail, occupancy, free credits, empty, full, err.
  function automatic logic [30:0] want(input logic [6:0] h, input logic [6:0] t, input int occ, input logic err);
    logic [6:0] o;
    logic [6:0] f;
    o = 7'(occ);
    f = 7'(41 - occ);
    return {h, t, o, f, (occ == 0), (occ == 41), err};
  endfunction

  // driver tasks
  task automatic drive(input logic [1:0] req, input logic [1:0] cv, input logic fl, input logic [6:0] fi);
    @(negedge clk);
    bus.alloc_req  = req;
    bus.cmpl_vld   = cv;
    bus.flush      = fl;
    bus.flush_itag = fi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] req, input logic [1:0] cv, input int n);
    for (int i = 0; i < n; i++) begin
      drive(req, cv, 1'b0, 7'h00);
      tick();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.alloc_req  = 2'b00;
    bus.cmpl_vld   = 2'b00;
    bus.flush      = 1'b0;
    bus.flush_itag = 7'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(2'b00, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if (bus.alloc_gnt !== 1'b0) begin
      n_err++; $display("FAIL reset_gnt: got %b want 0", bus.alloc_gnt);
    end
    n_vec++;
    if ({bus.alloc_itag0, bus.alloc_itag1} !== 14'h0001) begin
      n_err++; $display("FAIL reset_alloc_itags: got %h/%h want 00/01", bus.alloc_itag0, bus.alloc_itag1);
    end
    tick();
    exp_s = want(7'h00, 7'h00, 0, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL reset_state: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, 2'b00, 1'b0, 7'h00);
      #1;
      n_vec++;
      if (bus.alloc_gnt !== 1'b1) begin
        n_err++; $display("FAIL fill_gnt[%0d]: got %b want 1", i, bus.alloc_gnt);
      end
      tick();
    end
    exp_s = want(7'h00, 7'h28, 40, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL fill_40: got %h want %h", snap(), exp_s);
    end
    drive(2'b11, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if (bus.alloc_gnt !== 1'b0) begin
      n_err++; $display("FAIL fill_no_partial_gnt: got %b want 0", bus.alloc_gnt);
    end
    tick();
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL fill_denied_hold: got %h want %h", snap(), exp_s);
    end
    drive(2'b10, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if ({bus.alloc_gnt, bus.alloc_itag0} !== {1'b1, 7'h28}) begin
      n_err++; $display("FAIL fill_last_one: got gnt %b itag0 %h want 1/28", bus.alloc_gnt, bus.alloc_itag0);
    end
    tick();
    exp_s = want(7'h00, 7'h40, 41, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL fill_full: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_full_retire_alloc();
    drive(2'b11, 2'b11, 1'b0, 7'h00);
    #1;
    n_vec++;
    if (bus.alloc_gnt !== 1'b0) begin
      n_err++; $display("FAIL full_same_cycle_credit: got %b want 0", bus.alloc_gnt);
    end
    tick();
    exp_s = want(7'h02, 7'h40, 39, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL full_retire2: got %h want %h", snap(), exp_s);
    end
    drive(2'b11, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if ({bus.alloc_gnt, bus.alloc_itag0, bus.alloc_itag1} !== {1'b1, 7'h40, 7'h41}) begin
      n_err++; $display("FAIL full_regrant: got gnt %b itags %h/%h want 1 40/41", bus.alloc_gnt, bus.alloc_itag0, bus.alloc_itag1);
    end
    tick();
    exp_s = want(7'h02, 7'h42, 41, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL full_again: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_wrap_by_two();
    // tail index 39 + 2 folds to index 0
    do_reset();
    run(2'b11, 2'b00, 20);
    run(2'b00, 2'b11, 8);
    drive(2'b00, 2'b00, 1'b1, 7'h27);
    tick();
    exp_s = want(7'h10, 7'h27, 23, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL wrap39_setup: got %h want %h", snap(), exp_s);
    end
    drive(2'b11, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if ({bus.alloc_gnt, bus.alloc_itag1} !== {1'b1, 7'h28}) begin
      n_err++; $display("FAIL wrap39_itag1: got gnt %b itag1 %h want 1/28", bus.alloc_gnt, bus.alloc_itag1);
    end
    tick();
    exp_s = want(7'h10, 7'h40, 25, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL wrap39_tail: got %h want %h", snap(), exp_s);
    end
    // tail index 40 + 2 folds to index 1
    do_reset();
    run(2'b11, 2'b00, 20);
    run(2'b00, 2'b11, 16);
    drive(2'b11, 2'b00, 1'b0, 7'h00);
    #1;
    n_vec++;
    if ({bus.alloc_gnt, bus.alloc_itag0, bus.alloc_itag1} !== {1'b1, 7'h28, 7'h40}) begin
      n_err++; $display("FAIL wrap40_itags: got gnt %b itags %h/%h want 1 28/40", bus.alloc_gnt, bus.alloc_itag0, bus.alloc_itag1);
    end
    tick();
    exp_s = want(7'h20, 7'h41, 10, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL wrap40_tail: got %h want %h", snap(), exp_s);
    end
    // head crosses the same boundary by two
    run(2'b00, 2'b11, 4);
    exp_s = want(7'h28, 7'h41, 2, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL head40_setup: got %h want %h", snap(), exp_s);
    end
    run(2'b00, 2'b11, 1);
    exp_s = want(7'h41, 7'h41, 0, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL head_wrap2_empty: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_back_to_back();
    run(2'b11, 2'b00, 1);
    exp_s = want(7'h41, 7'h43, 2, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL b2b_alloc: got %h want %h", snap(), exp_s);
    end
    drive(2'b11, 2'b11, 1'b0, 7'h00);
    #1;
    n_vec++;
    if (bus.alloc_gnt !== 1'b1) begin
      n_err++; $display("FAIL b2b_gnt: got %b want 1", bus.alloc_gnt);
    end
    tick();
    exp_s = want(7'h43, 7'h45, 2, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL b2b_alloc_retire: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_flush();
    do_reset();
    run(2'b11, 2'b00, 16);
    run(2'b00, 2'b11, 2);
    run(2'b00, 2'b10, 1);
    exp_s = want(7'h05, 7'h20, 27, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL flush_setup: got %h want %h", snap(), exp_s);
    end
    drive(2'b11, 2'b00, 1'b1, 7'h10);
    #1;
    n_vec++;
    if (bus.alloc_gnt !== 1'b0) begin
      n_err++; $display("FAIL flush_blocks_gnt: got %b want 0", bus.alloc_gnt);
    end
    tick();
    exp_s = want(7'h05, 7'h10, 11, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL flush_restore: got %h want %h", snap(), exp_s);
    end
    drive(2'b00, 2'b11, 1'b1, 7'h08);
    tick();
    exp_s = want(7'h07, 7'h08, 1, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL flush_with_retire: got %h want %h", snap(), exp_s);
    end
    drive(2'b00, 2'b00, 1'b1, 7'h07);
    tick();
    exp_s = want(7'h07, 7'h07, 0, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL flush_to_head: got %h want %h", snap(), exp_s);
    end
  endtask

  task automatic test_over_retire();
    do_reset();
    run(2'b10, 2'b00, 1);
    run(2'b00, 2'b11, 1);
    exp_s = want(7'h00, 7'h01, 1, 1'b1);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL over_retire_err: got %h want %h", snap(), exp_s);
    end
    run(2'b00, 2'b00, 1);
    exp_s = want(7'h00, 7'h01, 1, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL over_retire_pulse: got %h want %h", snap(), exp_s);
    end
    run(2'b00, 2'b10, 1);
    exp_s = want(7'h01, 7'h01, 0, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL exact_retire: got %h want %h", snap(), exp_s);
    end
    run(2'b00, 2'b10, 1);
    exp_s = want(7'h01, 7'h01, 0, 1'b1);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL retire_empty_err: got %h want %h", snap(), exp_s);
    end
    run(2'b00, 2'b00, 1);
    exp_s = want(7'h01, 7'h01, 0, 1'b0);
    n_vec++;
    if (snap() !== exp_s) begin
      n_err++; $display("FAIL retire_empty_pulse: got %h want %h", snap(), exp_s);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.alloc_req  = 2'b00;
    bus.cmpl_vld   = 2'b00;
    bus.flush      = 1'b0;
    bus.flush_itag = 7'h00;
    test_reset();
    test_fill();
    test_full_retire_alloc();
    test_wrap_by_two();
    test_back_to_back();
    test_flush();
    test_over_retire();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
